// File: rtl/imem_boot_loader_if.sv
// Host-side byte stream and instruction-memory write port of the boot loader.
// The host drives the stream and the reload request. The loader drives the
// memory write port and the core reset/status outputs.
interface imem_boot_loader_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) ();
    logic [7:0]               byte_i;
    logic                     byte_valid_i;
    logic                     byte_ready_o;
    logic                     reload_i;
    logic                     we_o;
    logic [ADDRESS_WIDTH-1:0] waddr_o;
    logic [DATA_WIDTH-1:0]    wdata_o;
    logic                     core_rst_o;
    logic                     done_o;
    logic                     error_o;

    modport master (
        output byte_i, byte_valid_i, reload_i,
        input  byte_ready_o, we_o, waddr_o, wdata_o, core_rst_o, done_o, error_o
    );

    modport slave (
        input  byte_i, byte_valid_i, reload_i,
        output byte_ready_o, we_o, waddr_o, wdata_o, core_rst_o, done_o, error_o
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader. It takes a byte stream (count byte N, then
// 4*N payload bytes), packs the payload little-endian into words, writes the
// words to consecutive addresses and then releases the core from reset.
// Optional macro BOOT_CHECKSUM_EN: a trailing XOR checksum byte is expected
// and verified before the core is released.
//
// state | meaning
// IDLE  | waiting for the word-count byte
// LOAD  | collecting the 4 bytes of the current word
// WRITE | one-cycle write pulse of the assembled word
// CHECK | waiting for the checksum byte (BOOT_CHECKSUM_EN only)
// HOLD  | keeping the core in reset for HOLD_CYCLES cycles
// RUN   | image loaded, core running
// ERROR | load aborted, core held in reset
module imem_boot_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_SIZE      = 10,
    parameter int HOLD_CYCLES   = 4
) (
    input  logic clk,
    input  logic rst,
    imem_boot_loader_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;
    localparam logic [2:0] RUN   = 3'd5;
    localparam logic [2:0] ERROR = 3'd6;

    localparam int WIW = $clog2(MEM_SIZE + 1);
    localparam int HCW = $clog2(HOLD_CYCLES + 1);

    logic [2:0]            state;
    logic [1:0]            byte_cnt;
    logic [WIW-1:0]        word_idx;
    logic [WIW-1:0]        word_cnt;
    logic [HCW-1:0]        hold_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]            xor_q;
`endif
    logic                  ready;
    logic                  accept;

    assign ready  = (state == IDLE) || (state == LOAD) || (state == CHECK);
    assign accept = bus.byte_valid_i && ready;

    // Sequencer: byte collection, word writes, hold countdown and reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            word_idx <= '0;
            word_cnt <= '0;
            hold_cnt <= '0;
            shift_q  <= '0;
`ifdef BOOT_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.byte_i == 8'd0 || 32'(bus.byte_i) > MEM_SIZE) begin
                            state <= ERROR;
                        end else begin
                            word_cnt <= WIW'(bus.byte_i);
                            word_idx <= '0;
                            byte_cnt <= '0;
                            shift_q  <= '0;
`ifdef BOOT_CHECKSUM_EN
                            xor_q    <= '0;
`endif
                            state    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        // Little-endian: the first byte ends up in bits [7:0].
                        shift_q  <= {bus.byte_i, shift_q[DATA_WIDTH-1:8]};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                        xor_q    <= xor_q ^ bus.byte_i;
`endif
                        if (byte_cnt == 2'd3)
                            state <= WRITE;
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + WIW'(1);
                    if (word_idx + WIW'(1) == word_cnt) begin
`ifdef BOOT_CHECKSUM_EN
                        state    <= CHECK;
`else
                        state    <= HOLD;
                        hold_cnt <= HCW'(HOLD_CYCLES - 1);
`endif
                    end else begin
                        state <= LOAD;
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if (bus.byte_i == xor_q) begin
                            state    <= HOLD;
                            hold_cnt <= HCW'(HOLD_CYCLES - 1);
                        end else begin
                            state <= ERROR;
                        end
                    end
                end
`endif
                HOLD: begin
                    if (hold_cnt == '0)
                        state <= RUN;
                    else
                        hold_cnt <= hold_cnt - HCW'(1);
                end
                RUN, ERROR: begin
                    // Memory is left intact; the next image overwrites it.
                    if (bus.reload_i) begin
                        state    <= IDLE;
                        byte_cnt <= '0;
                        word_idx <= '0;
                        hold_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready_o = ready;
    assign bus.we_o         = (state == WRITE);
    assign bus.waddr_o      = ADDRESS_WIDTH'({word_idx, 2'b00});
    assign bus.wdata_o      = shift_q;
    assign bus.core_rst_o   = (state != RUN);
    assign bus.done_o       = (state == RUN);
    assign bus.error_o      = (state == ERROR);
endmodule
